// File: rtl/rom_fetch.sv
// rom_fetch: PC owner and one-entry fetch slot feeding decode via valid/ready, with sticky ROM fault.
// Optional ROM_FETCH_WRAP_FAULT_EN: fetching past the top address raises a fault instead of wrapping.
module rom_fetch #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  input  logic                  rom_error_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  fault_o,
  output logic [ADDR_WIDTH-1:0] fault_addr_o
);
  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_e;
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_out_q, fault_addr_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  valid_q, fault_q, hs, load;
  assign hs   = valid_q && ready_i;
  assign load = state_q == RUN && en_i && (!valid_q || ready_i) && !redirect_i;
  assign pc_d = pc_q + ADDR_WIDTH'(1);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_ADDR;
      instr_q      <= '0;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else if (redirect_i) begin
      pc_q    <= redirect_addr_i;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      state_q <= en_i ? RUN : IDLE;
    end else if (load && rom_error_i) begin
      fault_q      <= 1'b1;
      fault_addr_q <= pc_q;
      state_q      <= FAULT;
      if (hs) valid_q <= 1'b0;
    end else if (load) begin
      instr_q  <= rom_data_i;
      pc_out_q <= pc_q;
      valid_q  <= 1'b1;
      pc_q     <= pc_d;
`ifdef ROM_FETCH_WRAP_FAULT_EN
      if (&pc_q) begin
        state_q      <= FAULT;
        fault_q      <= 1'b1;
        fault_addr_q <= '0;
      end
`endif
    end else begin
      if (hs) valid_q <= 1'b0;
      if (state_q == IDLE && en_i) state_q <= RUN;
      else if (state_q == RUN && !en_i) state_q <= IDLE;
    end
  end
  assign rom_addr_o   = pc_q;
  assign instr_o      = instr_q;
  assign pc_o         = pc_out_q;
  assign valid_o      = valid_q;
  assign fault_o      = fault_q;
  assign fault_addr_o = fault_addr_q;
endmodule

// File: tb/tb_rom_fetch.sv
// tb_rom_fetch: directed test-plan steps then random traffic against a cycle-level reference model.
// Honours ROM_FETCH_WRAP_FAULT_EN to match the build of the design.
module tb_rom_fetch;
  logic        clk = 0, rst = 1, en = 0, rdr = 0, rdy = 0;
  logic [7:0]  rdr_addr = 0;
  logic [7:0]  rom_addr, pc_o, fault_addr;
  logic [15:0] rom_data, instr;
  logic        rom_err, valid, fault;
  logic [15:0] rom [256];
  logic        err_mem [256];
  int          vecs = 0, errs = 0;
  int          mode = 0;
  logic [7:0]  m_pc = 0, m_pcout = 0, m_faddr = 0;
  logic [15:0] m_instr = 0;
  logic        m_valid = 0, m_fault = 0;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];
  assign rom_err  = err_mem[rom_addr];

  rom_fetch dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .redirect_i(rdr), .redirect_addr_i(rdr_addr),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data), .rom_error_i(rom_err),
    .instr_o(instr), .pc_o(pc_o), .valid_o(valid), .ready_i(rdy),
    .fault_o(fault), .fault_addr_o(fault_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: mode 0=idle 1=run 2=fault, advanced from the inputs seen at the edge.
  task automatic model();
    logic accept;
    accept = m_valid && rdy;
    if (rst) begin
      mode = 0; m_pc = 0; m_pcout = 0; m_instr = 0; m_valid = 0; m_fault = 0; m_faddr = 0;
    end else if (rdr) begin
      m_pc = rdr_addr; m_valid = 0; m_fault = 0; mode = en ? 1 : 0;
    end else if (mode == 1 && en && (!m_valid || rdy)) begin
      if (err_mem[m_pc]) begin
        m_fault = 1; m_faddr = m_pc; mode = 2;
        if (accept) m_valid = 0;
      end else begin
        m_instr = rom[m_pc]; m_pcout = m_pc; m_valid = 1;
`ifdef ROM_FETCH_WRAP_FAULT_EN
        if (m_pc == 8'd255) begin mode = 2; m_fault = 1; m_faddr = 0; end
`endif
        m_pc = 8'((int'(m_pc) + 1) % 256);
      end
    end else begin
      if (accept) m_valid = 0;
      if (mode == 0 && en) mode = 1;
      else if (mode == 1 && !en) mode = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("rom_addr", 32'(rom_addr), 32'(m_pc));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("fault_addr", 32'(fault_addr), 32'(m_faddr));
    chk("instr", 32'(instr), 32'(m_instr));
    chk("pc_o", 32'(pc_o), 32'(m_pcout));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin rom[i] = 16'(i + 'h100); err_mem[i] = 0; end
    // reset and startup
    step();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    rst = 0; en = 1; rdy = 1;
    step();
    chk("startup_bubble", 32'(valid), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stream_instr", 32'(instr), 32'('h100 + i));
      chk("stream_pc", 32'(pc_o), 32'(i));
    end
    // backpressure
    rdy = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_pc", 32'(pc_o), 3);
      chk("hold_addr", 32'(rom_addr), 4);
    end
    rdy = 1;
    step();
    chk("resume_pc", 32'(pc_o), 4);
    // redirect with a valid word in the slot
    rdr = 1; rdr_addr = 8'h40;
    step();
    chk("rdr_flush", 32'(valid), 0);
    chk("rdr_addr", 32'(rom_addr), 'h40);
    rdr = 0;
    step();
    chk("rdr_pc", 32'(pc_o), 'h40);
    chk("rdr_instr", 32'(instr), 'h140);
    // ROM error at 0x10
    err_mem[8'h10] = 1;
    rdr = 1; rdr_addr = 8'h0e;
    step();
    rdr = 0;
    repeat (3) step();
    chk("err_fault", 32'(fault), 1);
    chk("err_faddr", 32'(fault_addr), 'h10);
    repeat (3) step();
    chk("err_noload", 32'(valid), 0);
    err_mem[8'h10] = 0;
    rdr = 1; rdr_addr = 8'h20;
    step();
    chk("clr_fault", 32'(fault), 0);
    rdr = 0;
    step();
    chk("resume_20", 32'(pc_o), 'h20);
    // top-of-memory wrap
    rdr = 1; rdr_addr = 8'hfe;
    step();
    rdr = 0;
    step();
    step();
    chk("wrap_ff", 32'(pc_o), 'hff);
    chk("wrap_ff_instr", 32'(instr), 'h1ff);
    step();
`ifdef ROM_FETCH_WRAP_FAULT_EN
    chk("wrap_fault", 32'(fault), 1);
    chk("wrap_faddr", 32'(fault_addr), 0);
`else
    chk("wrap_00", 32'(pc_o), 0);
    chk("wrap_nofault", 32'(fault), 0);
`endif
    // reset out of FAULT
    err_mem[8'h31] = 1;
    rdr = 1; rdr_addr = 8'h30;
    step();
    rdr = 0;
    repeat (3) step();
    chk("pre_rst_fault", 32'(fault), 1);
    err_mem[8'h31] = 0;
    rst = 1;
    step();
    chk("rst_fault", 32'(fault), 0);
    chk("rst_addr2", 32'(rom_addr), 0);
    chk("rst_pc_o", 32'(pc_o), 0);
    rst = 0;
    // random traffic
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'($urandom);
      err_mem[i] = ($urandom_range(0, 31) == 0);
    end
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      rdr = ($urandom_range(0, 19) == 0);
      rdr_addr = 8'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
